// File: rtl/branch_resolve.sv
// Resolves conditional branches and JALR for a sequential-predicting fetch unit.
// One-entry result register; taken, aligned transfers pulse a redirect and flip the fetch epoch.
module branch_resolve #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_epoch,
    input  logic            in_is_jalr,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_link,
    output logic            out_taken,
    output logic [1:0]      out_exc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            epoch
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_FUNCT3   = 2'd1;
    localparam logic [1:0] EXC_MISALIGN = 2'd2;

    logic            out_valid_reg;
    logic [XLEN-1:0] out_link_reg;
    logic            out_taken_reg;
    logic [1:0]      out_exc_reg;
    logic            redirect_valid_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic            epoch_reg;

    logic            accept;
    logic            current;
    logic            eq, lt, ltu;
    logic            cond_ok, cond_true;
    logic            taken_next;
    logic [1:0]      exc_next;
    logic            redirect_next;
    logic [XLEN-1:0] target_next;
    logic [XLEN-1:0] link_next;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign current  = (in_epoch == epoch_reg);

    assign eq  = (in_rs1 == in_rs2);
    assign lt  = ($signed(in_rs1) < $signed(in_rs2));
    assign ltu = (in_rs1 < in_rs2);

    always_comb begin
        cond_ok   = 1'b1;
        cond_true = 1'b0;
        case (in_funct3)
            3'b000:  cond_true = eq;
            3'b001:  cond_true = !eq;
            3'b100:  cond_true = lt;
            3'b101:  cond_true = !lt;
            3'b110:  cond_true = ltu;
            3'b111:  cond_true = !ltu;
            default: cond_ok   = 1'b0;
        endcase
    end

    // Adders wrap naturally at XLEN bits, so overflowing targets are not exceptions.
    always_comb begin
        link_next   = in_pc + XLEN'(4);
        target_next = in_is_jalr ? ((in_rs1 + in_imm) & JALR_MASK) : (in_pc + in_imm);
        taken_next  = in_is_jalr || (cond_ok && cond_true);
        exc_next    = EXC_NONE;
        if (!in_is_jalr && !cond_ok) begin
            exc_next = EXC_FUNCT3;
        end else if (taken_next && target_next[1]) begin
            exc_next = EXC_MISALIGN;
        end
        redirect_next = taken_next && (exc_next == EXC_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg      <= 1'b0;
            out_link_reg       <= '0;
            out_taken_reg      <= 1'b0;
            out_exc_reg        <= EXC_NONE;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            epoch_reg          <= 1'b0;
        end else begin
            redirect_valid_reg <= 1'b0;
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // Stale-epoch ops are consumed but leave no trace.
            if (accept && current) begin
                out_valid_reg <= 1'b1;
                out_link_reg  <= link_next;
                out_taken_reg <= taken_next;
                out_exc_reg   <= exc_next;
                if (redirect_next) begin
                    redirect_valid_reg <= 1'b1;
                    redirect_pc_reg    <= target_next;
                    epoch_reg          <= !epoch_reg;
                end
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_link       = out_link_reg;
    assign out_taken      = out_taken_reg;
    assign out_exc        = out_exc_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign epoch          = epoch_reg;

endmodule
